// File: rtl/reflet_interrupt_source.sv
// -----------------------------------------------------------------------------
// reflet_interrupt_source
//
// Front end for the four external interrupt lines feeding the CPU interrupt
// controller. Each channel is synchronised (2 flops), glitch filtered, and then
// either latched as a rising-edge request (edge channels) or passed straight
// through (level channels). Edge requests that arrive while the same channel is
// still pending are reported on the sticky lost flags.
//
// Parameters:
//   edge_mask    bit c = 1: channel c is rising-edge triggered and latched
//                bit c = 0: channel c is level triggered
//   filter_len   consecutive disagreeing cycles before the filtered value
//                follows the synchronised pin (0 = no filtering)
//   filter_width width of each per-channel filter counter
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   enable      global enable; low freezes filter, pending and lost state
//   irq_in      raw asynchronous pins, bit 0 = channel 0 = highest priority
//   int_mask    controller mask; selects which channel an acceptance clears
//   cpu_int     controller takes an interrupt this cycle
//   lost_clear  synchronous clear of all lost flags (works with enable low)
//   ext_int     interrupt requests to the controller
//   lost        sticky per-channel overrun flags
//
// Handshake: ext_int[c] is a request that stays asserted until accepted. An
// acceptance happens in a cycle with enable=1 and cpu_int=1, and it applies to
// the lowest channel c with ext_int[c] & int_mask[c]; that channel's pending
// request is dropped at the end of that cycle unless a new edge arrives in the
// same cycle. Level channels ignore acceptance entirely.
// -----------------------------------------------------------------------------
module reflet_interrupt_source #(
   parameter logic [3:0] edge_mask    = 4'b1111,
   parameter int         filter_len   = 2,
   parameter int         filter_width = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] irq_in,
   input  logic [3:0] int_mask,
   input  logic       cpu_int,
   input  logic       lost_clear,
   output logic [3:0] ext_int,
   output logic [3:0] lost
);

   localparam logic [filter_width-1:0] FLEN = filter_width'(filter_len);

   logic [3:0]              s1;
   logic [3:0]              s2;
   logic [3:0]              f;
   logic [filter_width-1:0] cnt [4];
   logic [3:0]              pending;
   logic [3:0]              lost_q;

   logic [3:0] load;      // filter output takes the synchronised value
   logic [3:0] rise;      // filter output goes 0 -> 1 this cycle
   logic [3:0] qual;      // channels eligible for acceptance
   logic [3:0] acc;       // one-hot accepted channel (or zero)
   logic [3:0] lost_set;

   always_comb begin
      load = '0;
      rise = '0;
      for (int c = 0; c < 4; c++) begin
         load[c] = enable && (s2[c] != f[c]) && (cnt[c] == FLEN);
         rise[c] = load[c] & s2[c];
      end
      qual     = (enable && cpu_int) ? (ext_int & int_mask) : 4'b0000;
      // Isolate the lowest set bit: channel 0 has the highest priority.
      acc      = qual & (~qual + 4'd1);
      lost_set = edge_mask & rise & pending & ~acc;
   end

   // Outputs come straight from flops; no combinational path from irq_in.
   assign ext_int = (edge_mask & pending) | (~edge_mask & f);
   assign lost    = lost_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1      <= '0;
         s2      <= '0;
         f       <= '0;
         pending <= '0;
         lost_q  <= '0;
         for (int c = 0; c < 4; c++) begin
            cnt[c] <= '0;
         end
      end else begin
         // The synchroniser keeps sampling while frozen so a pin change made
         // during enable=0 is seen by the filter as soon as enable returns.
         s1 <= irq_in;
         s2 <= s1;

         if (enable) begin
            for (int c = 0; c < 4; c++) begin
               if (s2[c] == f[c] || load[c]) begin
                  cnt[c] <= '0;
               end else begin
                  cnt[c] <= cnt[c] + 1'b1;
               end
            end
            f <= (f & ~load) | (s2 & load);
            // A new edge wins over a same-cycle acceptance on the channel.
            pending <= edge_mask & (rise | (pending & ~acc));
         end

         if (lost_clear) begin
            lost_q <= '0;
         end else if (enable) begin
            lost_q <= lost_q | lost_set;
         end
      end
   end

endmodule

// File: tb/tb_reflet_interrupt_source.sv
module tb_reflet_interrupt_source;

   localparam int FL = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       cpu_int = 1'b0;
   logic       lost_clear = 1'b0;
   logic [3:0] irq_in = 4'b0000;
   logic [3:0] int_mask = 4'b0000;
   logic [3:0] ext_a, lost_a, ext_b, lost_b;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   // Instance a: all channels edge triggered. Instance b: channel 0 is level.
   reflet_interrupt_source #(.edge_mask(4'b1111), .filter_len(FL), .filter_width(4)) dut_a (
      .clk(clk), .reset(reset), .enable(enable), .irq_in(irq_in), .int_mask(int_mask),
      .cpu_int(cpu_int), .lost_clear(lost_clear), .ext_int(ext_a), .lost(lost_a));

   reflet_interrupt_source #(.edge_mask(4'b1110), .filter_len(FL), .filter_width(4)) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .irq_in(irq_in), .int_mask(int_mask),
      .cpu_int(cpu_int), .lost_clear(lost_clear), .ext_int(ext_b), .lost(lost_b));

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Behavioural view: a pin value reaches the filtered output once the
   // synchronised pin has differed from it for FL+1 enabled cycles in a row.
   logic [3:0] m_s1 [2];
   logic [3:0] m_s2 [2];
   logic [3:0] m_f [2];
   logic [3:0] m_pend [2];
   logic [3:0] m_lost [2];
   int         m_run [2][4];

   function automatic logic [3:0] em(input int i);
      return (i == 0) ? 4'b1111 : 4'b1110;
   endfunction

   function automatic logic [3:0] m_ext(input int i);
      return (em(i) & m_pend[i]) | (~em(i) & m_f[i]);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            m_s1[i] = '0; m_s2[i] = '0; m_f[i] = '0; m_pend[i] = '0; m_lost[i] = '0;
            for (int c = 0; c < 4; c++) m_run[i][c] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            logic [3:0] cur;
            logic [3:0] rise;
            int acc;
            cur = m_ext(i);
            acc = -1;
            if (enable && cpu_int) begin
               for (int c = 3; c >= 0; c--) if (cur[c] && int_mask[c]) acc = c;
            end
            rise = '0;
            if (enable) begin
               for (int c = 0; c < 4; c++) begin
                  if (m_s2[i][c] != m_f[i][c]) begin
                     m_run[i][c] = m_run[i][c] + 1;
                     if (m_run[i][c] > FL) begin
                        m_f[i][c] = m_s2[i][c];
                        m_run[i][c] = 0;
                        rise[c] = m_f[i][c];
                     end
                  end else begin
                     m_run[i][c] = 0;
                  end
               end
            end
            if (lost_clear) begin
               m_lost[i] = '0;
            end else if (enable) begin
               for (int c = 0; c < 4; c++)
                  if (em(i)[c] && rise[c] && m_pend[i][c] && acc != c) m_lost[i][c] = 1'b1;
            end
            if (enable) begin
               for (int c = 0; c < 4; c++) begin
                  if (em(i)[c]) begin
                     if (rise[c]) m_pend[i][c] = 1'b1;
                     else if (acc == c) m_pend[i][c] = 1'b0;
                  end
               end
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = irq_in;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && reset) begin
         check("model_ext_a", ext_a, m_ext(0));
         check("model_lost_a", lost_a, m_lost[0]);
         check("model_ext_b", ext_b, m_ext(1));
         check("model_lost_b", lost_b, m_lost[1]);
      end
   end

   // ---------------- directed vector table (instance a) ----------------
   typedef struct {
      logic [3:0] irq;
      logic [3:0] msk;
      logic       cpu;
      logic       lclr;
      logic [3:0] ext;
      logic [3:0] lst;
   } vec_t;

   vec_t tbl[$];

   task automatic row(input int n, input logic [3:0] irq, input logic [3:0] msk, input logic cpu,
                      input logic lclr, input logic [3:0] ext, input logic [3:0] lst);
      vec_t v;
      v.irq = irq; v.msk = msk; v.cpu = cpu; v.lclr = lclr; v.ext = ext; v.lst = lst;
      repeat (n) tbl.push_back(v);
   endtask

   task automatic cyc(input int n, input logic [3:0] irq);
      repeat (n) begin
         irq_in = irq;
         @(negedge clk);
      end
   endtask

   task automatic pulse(input logic [3:0] irq);
      cyc(4, irq);
      cyc(6, 4'b0000);
   endtask

   initial begin
      // latency / filter on channel 1, then channel 2
      row(4, 4'b0010, 4'b1111, 0, 0, 4'b0000, 4'b0000);
      row(6, 4'b0000, 4'b1111, 0, 0, 4'b0010, 4'b0000);
      row(4, 4'b0100, 4'b1111, 0, 0, 4'b0010, 4'b0000);
      row(4, 4'b0000, 4'b1111, 0, 0, 4'b0110, 4'b0000);
      // acceptance priority
      row(1, 4'b0000, 4'b1111, 1, 0, 4'b0100, 4'b0000);
      row(1, 4'b0000, 4'b1111, 0, 0, 4'b0100, 4'b0000);
      row(4, 4'b0010, 4'b1111, 0, 0, 4'b0100, 4'b0000);
      row(1, 4'b0000, 4'b1111, 0, 0, 4'b0110, 4'b0000);
      row(1, 4'b0000, 4'b1100, 1, 0, 4'b0010, 4'b0000);
      row(1, 4'b0000, 4'b1111, 1, 0, 4'b0000, 4'b0000);
      row(1, 4'b0000, 4'b1111, 0, 0, 4'b0000, 4'b0000);
      // overrun on channel 3 and lost_clear
      row(4, 4'b1000, 4'b1111, 0, 0, 4'b0000, 4'b0000);
      row(5, 4'b0000, 4'b1111, 0, 0, 4'b1000, 4'b0000);
      row(4, 4'b1000, 4'b1111, 0, 0, 4'b1000, 4'b0000);
      row(1, 4'b0000, 4'b1111, 0, 0, 4'b1000, 4'b1000);
      row(1, 4'b0000, 4'b1111, 0, 1, 4'b1000, 4'b0000);
      row(1, 4'b0000, 4'b1111, 1, 0, 4'b0000, 4'b0000);
      // rise and acceptance on channel 0 in the same cycle
      row(4, 4'b0001, 4'b1111, 0, 0, 4'b0000, 4'b0000);
      row(5, 4'b0000, 4'b1111, 0, 0, 4'b0001, 4'b0000);
      row(4, 4'b0001, 4'b1111, 0, 0, 4'b0001, 4'b0000);
      row(1, 4'b0000, 4'b1111, 1, 0, 4'b0001, 4'b0000);
      row(1, 4'b0000, 4'b1111, 1, 0, 4'b0000, 4'b0000);

      // clock/reset
      repeat (3) @(negedge clk);
      check("reset_ext", ext_a, 4'b0000);
      check("reset_lost", lost_a, 4'b0000);
      reset = 1'b1;
      enable = 1'b1;
      int_mask = 4'b1111;
      chk_en = 1'b1;
      cyc(3, 4'b0000);

      foreach (tbl[k]) begin
         irq_in = tbl[k].irq;
         int_mask = tbl[k].msk;
         cpu_int = tbl[k].cpu;
         lost_clear = tbl[k].lclr;
         @(posedge clk);
         #1;
         check($sformatf("tbl_ext[%0d]", k), ext_a, tbl[k].ext);
         check($sformatf("tbl_lost[%0d]", k), lost_a, tbl[k].lst);
         @(negedge clk);
      end
      cpu_int = 1'b0;
      lost_clear = 1'b0;
      int_mask = 4'b1111;

      // glitch: 2-cycle synchronised pulse must be filtered out
      cyc(6, 4'b0000);
      cyc(2, 4'b0010);
      cyc(8, 4'b0000);
      check("glitch_ext", ext_a, 4'b0000);

      // build pending=0101, lost=0001, then asynchronous reset
      pulse(4'b0001);
      pulse(4'b0100);
      pulse(4'b0001);
      check("pre_reset_ext", ext_a, 4'b0101);
      check("pre_reset_lost", lost_a, 4'b0001);
      #2 reset = 1'b0;
      #1;
      check("async_reset_ext", ext_a, 4'b0000);
      check("async_reset_lost", lost_a, 4'b0000);
      @(negedge clk);
      reset = 1'b1;
      cyc(4, 4'b0000);
      check("post_reset_ext", ext_a, 4'b0000);
      check("post_reset_lost", lost_a, 4'b0000);

      // level channel 0 on instance b ignores cpu_int
      cpu_int = 1'b1;
      cyc(5, 4'b0001);
      check("level_ext_b0", {3'b000, ext_b[0]}, 4'b0001);
      cyc(3, 4'b0001);
      check("level_hold_b0", {3'b000, ext_b[0]}, 4'b0001);
      cpu_int = 1'b0;
      cyc(8, 4'b0000);
      check("level_fall_b0", {3'b000, ext_b[0]}, 4'b0000);
      cpu_int = 1'b1;
      cyc(2, 4'b0000);
      cpu_int = 1'b0;

      // pin change while frozen is filtered only after enable returns
      enable = 1'b0;
      cyc(5, 4'b0100);
      check("frozen_ext2", {1'b0, ext_a[2], 2'b00}, 4'b0000);
      enable = 1'b1;
      cyc(2, 4'b0100);
      check("enable_early_ext2", {1'b0, ext_a[2], 2'b00}, 4'b0000);
      cyc(1, 4'b0100);
      check("enable_ext2_a", {1'b0, ext_a[2], 2'b00}, 4'b0100);
      check("enable_ext2_b", {1'b0, ext_b[2], 2'b00}, 4'b0100);
      cyc(6, 4'b0000);

      // randomized stimulus against the model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ 4'($urandom_range(0, 15));
         enable = ($urandom_range(0, 9) != 0);
         cpu_int = $urandom_range(0, 1) == 1;
         int_mask = 4'($urandom_range(0, 15));
         lost_clear = ($urandom_range(0, 15) == 0);
         @(negedge clk);
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
